// File: rtl/miniRV_pkg.sv
// miniRV shared types: npc_op encodings, fetch FSM states, NOP word.
// Imported by fetch_npc_unit and npc_calc.
package miniRV_pkg;

  typedef enum logic [1:0] {
    NPC_BR   = 2'b00,
    NPC_JALR = 2'b01,
    NPC_PC4  = 2'b10,
    NPC_JAL  = 2'b11
  } npc_op_e;

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_HOLD = 2'b11
  } fetch_state_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_npc_unit_npc_calc.sv
// npc_calc: raw next-PC from pc, npc_op, br_taken, imm, rs1_data.
// Out: next_pc (alignment fix-up is applied by the caller).
module npc_calc
  import miniRV_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  npc_op,
  input  logic        br_taken,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_data,
  output logic [31:0] next_pc
);

  logic [31:0] seq;
  logic [31:0] rel;
  logic [31:0] ind;

  assign seq = pc + 32'd4;
  assign rel = pc + imm;
  assign ind = (rs1_data + imm) & ~32'h1;

  always_comb begin
    next_pc = seq;
    unique case (npc_op)
      NPC_BR:   next_pc = br_taken ? rel : seq;
      NPC_JALR: next_pc = ind;
      NPC_PC4:  next_pc = seq;
      NPC_JAL:  next_pc = rel;
    endcase
  end

endmodule

// File: rtl/fetch_npc_unit.sv
// fetch_npc_unit: PC holder, single-outstanding imem fetch, next-PC commit.
// Ports: clk/rst_n, npc_op/br_taken/imm/rs1_data/ex_done from the core,
// imem_req_*/imem_rsp_* to memory, inst/inst_valid/pc/pc4/trap to decode.
// MISALIGN_TRAP_EN: misaligned commit target redirects to TRAP_VEC and
// pulses trap; otherwise the target's low two bits are cleared.
module fetch_npc_unit
  import miniRV_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  npc_op,
  input  logic        br_taken,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_data,
  input  logic        ex_done,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic        trap
);

  fetch_state_e state;
  fetch_state_e state_nxt;

  logic [31:0] npc_raw;
  logic [31:0] npc_fix;
  logic        misalign;
  logic        commit;

  npc_calc u_npc_calc (
    .pc       (pc),
    .npc_op   (npc_op),
    .br_taken (br_taken),
    .imm      (imm),
    .rs1_data (rs1_data),
    .next_pc  (npc_raw)
  );

`ifdef MISALIGN_TRAP_EN
  assign misalign = |npc_raw[1:0];
`else
  assign misalign = 1'b0;
`endif

  // Without the trap, misalign is 0 and this just clears bits [1:0].
  assign npc_fix = misalign ? TRAP_VEC : (npc_raw & ~32'h3);
  assign commit  = (state == ST_HOLD) && ex_done;

  assign imem_addr = pc;
  assign pc4       = pc + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_BOOT: state_nxt = ST_REQ;
      ST_REQ:  if (imem_req_ready) state_nxt = ST_WAIT;
      ST_WAIT: if (imem_rsp_valid) state_nxt = ST_HOLD;
      ST_HOLD: if (ex_done) state_nxt = ST_REQ;
    endcase
  end

  always_comb begin
    imem_req_valid = 1'b0;
    inst_valid     = 1'b0;
    trap           = 1'b0;
    unique case (state)
      ST_REQ:  imem_req_valid = 1'b1;
      ST_HOLD: begin
        inst_valid = 1'b1;
        trap       = ex_done && misalign;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc   <= RESET_PC;
      inst <= NOP;
    end else begin
      if (state == ST_WAIT && imem_rsp_valid) inst <= imem_rsp_data;
      if (commit) pc <= npc_fix;
    end
  end

endmodule

// File: tb/tb_fetch_npc_unit.sv
// Bench for fetch_npc_unit: directed vector table, hand sequences for
// stalls/spurious responses/reset, then randomized traffic vs a model.
module tb_fetch_npc_unit;
  import miniRV_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] TVEC   = 32'h0000_0100;

  logic        clk;
  logic        rst_n;
  logic [1:0]  npc_op;
  logic        br_taken;
  logic [31:0] imm;
  logic [31:0] rs1_data;
  logic        ex_done;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        trap;

  fetch_npc_unit #(
    .RESET_PC (RST_PC),
    .TRAP_VEC (TVEC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .npc_op         (npc_op),
    .br_taken       (br_taken),
    .imm            (imm),
    .rs1_data       (rs1_data),
    .ex_done        (ex_done),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst           (inst),
    .inst_valid     (inst_valid),
    .pc             (pc),
    .pc4            (pc4),
    .trap           (trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [1:0]  op;
    logic        br;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] word;
    logic [31:0] exp_next;
    logic        exp_trap;
  } vec_t;

  vec_t tbl [11];

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] mpc;
  logic [31:0] last_word;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: architectural next-PC rules with plain arithmetic.
  function automatic logic [32:0] model_next(
    input logic [31:0] cur, input logic [1:0] op, input logic br,
    input logic [31:0] v_imm, input logic [31:0] v_rs1);
    logic [31:0] t;
    case (op)
      2'b10:   t = cur + 4;
      2'b11:   t = cur + v_imm;
      2'b00:   t = br ? cur + v_imm : cur + 4;
      default: t = (v_rs1 + v_imm) & 32'hFFFF_FFFE;
    endcase
`ifdef MISALIGN_TRAP_EN
    if (t % 4 != 0) return {1'b1, TVEC};
    return {1'b0, t};
`else
    return {1'b0, t - (t % 4)};
`endif
  endfunction

  task automatic do_fetch(input int rdly, input int pdly,
                          input logic [31:0] word);
    int n;
    n = 0;
    while (imem_req_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_valid", 32'(imem_req_valid), 32'd1);
    chk("imem_addr", imem_addr, mpc);
    for (int i = 0; i < rdly; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(imem_req_valid), 32'd1);
      chk("stall_addr", imem_addr, mpc);
    end
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    for (int i = 0; i < pdly; i++) begin
      chk("wait_no_inst_valid", 32'(inst_valid), 32'd0);
      @(negedge clk);
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = word;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    chk("inst_valid", 32'(inst_valid), 32'd1);
    chk("inst", inst, word);
    chk("pc", pc, mpc);
    chk("pc4", pc4, mpc + 32'd4);
    last_word = word;
  endtask

  task automatic do_commit(input logic [1:0] v_op, input logic v_br,
                           input logic [31:0] v_imm,
                           input logic [31:0] v_rs1,
                           input logic [31:0] exp_next,
                           input logic exp_trap);
    npc_op   = v_op;
    br_taken = v_br;
    imm      = v_imm;
    rs1_data = v_rs1;
    ex_done  = 1'b1;
    #1;
    chk("trap", 32'(trap), 32'(exp_trap));
    chk("hold_pc", pc, mpc);
    @(negedge clk);
    ex_done = 1'b0;
    #1;
    chk("next_pc", pc, exp_next);
    chk("trap_clear", 32'(trap), 32'd0);
    chk("inst_valid_drop", 32'(inst_valid), 32'd0);
    mpc = exp_next;
  endtask

  initial begin
    logic [32:0] r;
    logic [1:0]  rop;
    logic        rbr;
    logic [31:0] rimm;
    logic [31:0] rrs1;

    tbl[0]  = '{2'b10, 1'b0, 32'h0,         32'h0,         32'h0010_0093, 32'h4,    1'b0};
    tbl[1]  = '{2'b10, 1'b0, 32'h0,         32'h0,         32'h0020_0113, 32'h8,    1'b0};
    tbl[2]  = '{2'b11, 1'b0, 32'h18,        32'h0,         32'h0180_006F, 32'h20,   1'b0};
    tbl[3]  = '{2'b00, 1'b1, 32'hFFFF_FFF0, 32'h0,         32'hFE00_08E3, 32'h10,   1'b0};
    tbl[4]  = '{2'b11, 1'b0, 32'h10,        32'h0,         32'h0100_006F, 32'h20,   1'b0};
    tbl[5]  = '{2'b00, 1'b0, 32'hFFFF_FFF0, 32'h0,         32'hFE00_08E3, 32'h24,   1'b0};
    tbl[6]  = '{2'b01, 1'b0, 32'h4,         32'h0000_1001, 32'h0040_8067, 32'h1004, 1'b0};
    tbl[7]  = '{2'b11, 1'b0, 32'hFFFF_EFFC, 32'h0,         32'hAAAA_5555, 32'h0,    1'b0};
    tbl[8]  = '{2'b01, 1'b0, 32'h8,         32'hFFFF_FFFC, 32'h1234_5678, 32'h4,    1'b0};
    tbl[9]  = '{2'b11, 1'b0, 32'hFFFF_FFFC, 32'h0,         32'h8765_4321, 32'h0,    1'b0};
`ifdef MISALIGN_TRAP_EN
    tbl[10] = '{2'b11, 1'b0, 32'h6,         32'h0,         32'h0060_006F, 32'h100,  1'b1};
`else
    tbl[10] = '{2'b11, 1'b0, 32'h6,         32'h0,         32'h0060_006F, 32'h4,    1'b0};
`endif

    rst_n          = 1'b0;
    npc_op         = 2'b10;
    br_taken       = 1'b0;
    imm            = 32'h0;
    rs1_data       = 32'h0;
    ex_done        = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    last_word      = NOP;

    repeat (2) @(negedge clk);
    chk("rst_pc", pc, RST_PC);
    chk("rst_inst", inst, 32'h0000_0013);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_trap", 32'(trap), 32'd0);

    rst_n = 1'b1;
    #1;
    chk("boot_no_req", 32'(imem_req_valid), 32'd0);
    @(negedge clk);
    chk("boot_one_cycle", 32'(imem_req_valid), 32'd1);
    mpc = RST_PC;

    for (int i = 0; i < 11; i++) begin
      do_fetch(0, 0, tbl[i].word);
      do_commit(tbl[i].op, tbl[i].br, tbl[i].imm, tbl[i].rs1,
                tbl[i].exp_next, tbl[i].exp_trap);
    end

    // Stall in REQ with a spurious response and a stray ex_done.
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    npc_op         = 2'b11;
    imm            = 32'h40;
    ex_done        = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("st_valid", 32'(imem_req_valid), 32'd1);
      chk("st_addr", imem_addr, mpc);
      chk("st_inst", inst, last_word);
      chk("st_pc", pc, mpc);
      chk("st_trap", 32'(trap), 32'd0);
    end
    ex_done        = 1'b0;
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    chk("hs_rsp_ignored", inst, last_word);
    chk("hs_wait_no_req", 32'(imem_req_valid), 32'd0);
    chk("hs_wait_inst_valid", 32'(inst_valid), 32'd0);
    ex_done = 1'b1;
    @(negedge clk);
    ex_done = 1'b0;
    chk("wait_ex_done_ignored", pc, mpc);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0BAD_F00D;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    chk("late_inst_valid", 32'(inst_valid), 32'd1);
    chk("late_inst", inst, 32'h0BAD_F00D);
    last_word = 32'h0BAD_F00D;
    do_commit(2'b10, 1'b0, 32'h0, 32'h0, mpc + 32'd4, 1'b0);

    // Reset while WAITing; the late response must be dropped.
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pc", pc, RST_PC);
    chk("mid_rst_inst", inst, 32'h0000_0013);
    chk("mid_rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("mid_rst_req", 32'(imem_req_valid), 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hCAFE_F00D;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_boot_no_req", 32'(imem_req_valid), 32'd0);
    @(negedge clk);
    chk("drop_inst", inst, 32'h0000_0013);
    chk("drop_inst_valid", 32'(inst_valid), 32'd0);
    chk("drop_req", 32'(imem_req_valid), 32'd1);
    chk("drop_addr", imem_addr, RST_PC);
    imem_rsp_valid = 1'b0;
    mpc = RST_PC;

    for (int i = 0; i < 40; i++) begin
      rop  = 2'($urandom_range(0, 3));
      rbr  = 1'($urandom_range(0, 1));
      rimm = ($urandom_range(0, 3) == 0) ? $urandom :
             32'($urandom_range(0, 64)) * 2 - 32'd64;
      rrs1 = $urandom;
      r    = model_next(mpc, rop, rbr, rimm, rrs1);
      do_fetch($urandom_range(0, 3), $urandom_range(0, 3), $urandom);
      do_commit(rop, rbr, rimm, rrs1, r[31:0], r[32]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
